// File: rtl/osr_if.sv
// osr_if: TX-FIFO, control and shift-output signals of the output shift register
interface osr_if;
    logic        in_shiftDirection;
    logic        in_outEnable;
    logic [4:0]  in_bitReqLength;
    logic        in_pullNow;
    logic        in_autoPullEnable;
    logic [4:0]  in_pullThreshold;
    logic        in_load;
    logic [31:0] in_loadData;
    logic [31:0] in_fifoData;
    logic        in_fifoEmpty;
    logic        out_fifoPop;
    logic [31:0] out_data;
    logic        out_empty;
    logic        out_stall;
    logic [5:0]  out_shiftCount;
    modport slave (
        input  in_shiftDirection, in_outEnable, in_bitReqLength, in_pullNow,
               in_autoPullEnable, in_pullThreshold, in_load, in_loadData,
               in_fifoData, in_fifoEmpty,
        output out_fifoPop, out_data, out_empty, out_stall, out_shiftCount
    );
    modport master (
        output in_shiftDirection, in_outEnable, in_bitReqLength, in_pullNow,
               in_autoPullEnable, in_pullThreshold, in_load, in_loadData,
               in_fifoData, in_fifoEmpty,
        input  out_fifoPop, out_data, out_empty, out_stall, out_shiftCount
    );
endinterface

// File: rtl/osr.sv
// osr: PIO output shift register with explicit PULL, auto-pull and stall
module osr (
    input  logic clk,
    input  logic reset,
    osr_if.slave bus
);
    logic [31:0] word_q, word_d;
    logic [5:0]  count_q, count_d;
    logic [5:0]  n, t;
    logic [6:0]  sum;
    logic        empty;

    assign n     = bus.in_bitReqLength == 5'd0 ? 6'd32 : {1'b0, bus.in_bitReqLength};
    assign t     = bus.in_pullThreshold == 5'd0 ? 6'd32 : {1'b0, bus.in_pullThreshold};
    assign empty = count_q >= t;
    assign sum   = {1'b0, count_q} + {1'b0, n};
    assign bus.out_empty      = empty;
    assign bus.out_shiftCount = count_q;

    // Prioritised load / pull / auto-pull / shift / idle refill decision
    always_comb begin
        word_d          = word_q;
        count_d         = count_q;
        bus.out_fifoPop = 1'b0;
        bus.out_stall   = 1'b0;
        bus.out_data    = 32'd0;
        if (bus.in_load) begin
            word_d  = bus.in_loadData;
            count_d = 6'd0;
        end else if (bus.in_pullNow || (bus.in_outEnable && bus.in_autoPullEnable && empty)) begin
            // An auto-pull stalls even on success so the OUT retries on the fresh word
            bus.out_stall   = bus.in_fifoEmpty || !bus.in_pullNow;
            bus.out_fifoPop = !bus.in_fifoEmpty;
            word_d          = bus.in_fifoEmpty ? word_q : bus.in_fifoData;
            count_d         = bus.in_fifoEmpty ? count_q : 6'd0;
        end else if (bus.in_outEnable) begin
            // Shift amounts of 32 naturally yield 0 for the vacated word
            bus.out_data = bus.in_shiftDirection ? (word_q & ~(32'hFFFF_FFFF << n))
                                                 : (word_q >> (6'd32 - n));
            word_d       = bus.in_shiftDirection ? (word_q >> n) : (word_q << n);
            count_d      = sum > 7'd32 ? 6'd32 : sum[5:0];
        end else if (bus.in_autoPullEnable && empty && !bus.in_fifoEmpty) begin
            bus.out_fifoPop = 1'b1;
            word_d          = bus.in_fifoData;
            count_d         = 6'd0;
        end
    end

    // Shift word and consumed-bit count; reset leaves the OSR empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q  <= 32'd0;
            count_q <= 6'd32;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_osr.sv
// tb_osr: directed stimulus checked against an arithmetic OSR model every cycle
module tb_osr;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    osr_if bus();
    osr dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    longint mw, nw;
    int     mc, nc;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: evaluate the word as an unsigned number, shifting by division/multiplication
    always @(negedge clk) begin
        int     n, t;
        longint p, e_data;
        bit     e_pop, e_stall;
        n = bus.in_bitReqLength == 0 ? 32 : int'(bus.in_bitReqLength);
        t = bus.in_pullThreshold == 0 ? 32 : int'(bus.in_pullThreshold);
        p = longint'(1) << n;
        e_pop = 0; e_stall = 0; e_data = 0; nw = mw; nc = mc;
        if (bus.in_load) begin
            nw = longint'(bus.in_loadData); nc = 0;
        end else if (bus.in_pullNow) begin
            if (bus.in_fifoEmpty) e_stall = 1;
            else begin e_pop = 1; nw = longint'(bus.in_fifoData); nc = 0; end
        end else if (bus.in_outEnable && bus.in_autoPullEnable && mc >= t) begin
            e_stall = 1;
            if (!bus.in_fifoEmpty) begin e_pop = 1; nw = longint'(bus.in_fifoData); nc = 0; end
        end else if (bus.in_outEnable) begin
            if (bus.in_shiftDirection) begin
                e_data = mw % p; nw = mw / p;
            end else begin
                e_data = mw / (longint'(1) << (32 - n)); nw = (mw * p) % (longint'(1) << 32);
            end
            nc = (mc + n > 32) ? 32 : mc + n;
        end else if (bus.in_autoPullEnable && mc >= t && !bus.in_fifoEmpty) begin
            e_pop = 1; nw = longint'(bus.in_fifoData); nc = 0;
        end
        if (!reset) begin
            chk("m_pop",   longint'(bus.out_fifoPop), longint'(e_pop));
            chk("m_stall", longint'(bus.out_stall), longint'(e_stall));
            chk("m_data",  longint'(bus.out_data), e_data);
            chk("m_empty", longint'(bus.out_empty), longint'(mc >= t));
            chk("m_count", longint'(bus.out_shiftCount), longint'(mc));
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin mw <= 0; mc <= 32; end
        else begin mw <= nw; mc <= nc; end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        bus.in_shiftDirection = 1; bus.in_outEnable = 0; bus.in_bitReqLength = 0;
        bus.in_pullNow = 0; bus.in_autoPullEnable = 1; bus.in_pullThreshold = 0;
        bus.in_load = 0; bus.in_loadData = 0;
        bus.in_fifoData = 32'hDEADBEEF; bus.in_fifoEmpty = 0;
        tick(); tick();
        reset = 0;
        neg(); chk("rst_pop", bus.out_fifoPop, 1); chk("rst_empty", bus.out_empty, 1);
        chk("rst_count", bus.out_shiftCount, 32); chk("rst_data", bus.out_data, 0);
        tick(); bus.in_fifoEmpty = 1;
        neg(); chk("t1_count", bus.out_shiftCount, 0); chk("t1_pop", bus.out_fifoPop, 0);
        // right shift by 8 four times
        tick(); bus.in_autoPullEnable = 0; bus.in_outEnable = 1; bus.in_bitReqLength = 8;
        neg(); chk("t2_d0", bus.out_data, 32'hEF);
        tick(); neg(); chk("t2_d1", bus.out_data, 32'hBE); chk("t2_c1", bus.out_shiftCount, 8);
        tick(); neg(); chk("t2_d2", bus.out_data, 32'hAD); chk("t2_c2", bus.out_shiftCount, 16);
        tick(); neg(); chk("t2_d3", bus.out_data, 32'hDE); chk("t2_c3", bus.out_shiftCount, 24);
        tick(); bus.in_outEnable = 0;
        neg(); chk("t2_c4", bus.out_shiftCount, 32);
        // load with concurrent OUT, then left shift
        tick(); bus.in_load = 1; bus.in_loadData = 32'hDEADBEEF; bus.in_outEnable = 1;
        neg(); chk("t3_ld_data", bus.out_data, 0); chk("t3_ld_stall", bus.out_stall, 0);
        tick(); bus.in_load = 0; bus.in_shiftDirection = 0; bus.in_bitReqLength = 4;
        neg(); chk("t3_data", bus.out_data, 32'hD);
        tick(); bus.in_bitReqLength = 0;
        neg(); chk("t3_count", bus.out_shiftCount, 4); chk("t3_word", bus.out_data, 32'hEADBEEF0);
        tick(); bus.in_outEnable = 0;
        neg(); chk("t3_sat", bus.out_shiftCount, 32);
        // auto-pull on empty OSR with FIFO empty, then data arrives
        tick(); bus.in_autoPullEnable = 1; bus.in_outEnable = 1; bus.in_shiftDirection = 1;
        bus.in_bitReqLength = 8;
        neg(); chk("t4_stall0", bus.out_stall, 1); chk("t4_pop0", bus.out_fifoPop, 0);
        tick(); neg(); chk("t4_stall1", bus.out_stall, 1);
        tick(); bus.in_fifoData = 32'h12345678; bus.in_fifoEmpty = 0;
        neg(); chk("t4_pop", bus.out_fifoPop, 1); chk("t4_stall2", bus.out_stall, 1);
        chk("t4_data0", bus.out_data, 0);
        tick(); bus.in_fifoEmpty = 1;
        neg(); chk("t4_data", bus.out_data, 32'h78); chk("t4_stall3", bus.out_stall, 0);
        tick(); bus.in_outEnable = 0;
        neg(); chk("t4_count", bus.out_shiftCount, 8);
        // blocking PULL waits 3 cycles
        tick(); bus.in_autoPullEnable = 0; bus.in_pullNow = 1;
        for (int i = 0; i < 3; i++) begin
            neg(); chk("t5_stall", bus.out_stall, 1); tick();
        end
        bus.in_fifoData = 32'hA5A5A5A5; bus.in_fifoEmpty = 0;
        neg(); chk("t5_pop", bus.out_fifoPop, 1); chk("t5_stall_done", bus.out_stall, 0);
        tick(); bus.in_pullNow = 0; bus.in_fifoEmpty = 1;
        neg(); chk("t5_count", bus.out_shiftCount, 0);
        // load beats OUT, then a 32-bit OUT
        tick(); bus.in_load = 1; bus.in_loadData = 32'hFFFF0000; bus.in_outEnable = 1;
        bus.in_bitReqLength = 0;
        neg(); chk("t6_ld_data", bus.out_data, 0);
        tick(); bus.in_load = 0;
        neg(); chk("t6_data", bus.out_data, 32'hFFFF0000);
        tick(); neg(); chk("t6_count", bus.out_shiftCount, 32); chk("t6_drained", bus.out_data, 0);
        // non-32 threshold: OUT 8 reaches T=8, idle refill follows
        tick(); bus.in_load = 1; bus.in_loadData = 32'h0000_00C3; bus.in_outEnable = 0;
        tick(); bus.in_load = 0; bus.in_autoPullEnable = 1; bus.in_pullThreshold = 8;
        bus.in_outEnable = 1; bus.in_bitReqLength = 8;
        neg(); chk("t7_data", bus.out_data, 32'hC3);
        tick(); bus.in_outEnable = 0; bus.in_fifoData = 32'h0F0F_0F0F; bus.in_fifoEmpty = 0;
        neg(); chk("t7_empty", bus.out_empty, 1); chk("t7_refill", bus.out_fifoPop, 1);
        tick(); bus.in_fifoEmpty = 1; bus.in_outEnable = 1; bus.in_shiftDirection = 0;
        bus.in_bitReqLength = 3;
        neg(); chk("t7_left3", bus.out_data, 0);
        tick(); bus.in_bitReqLength = 5;
        neg(); chk("t7_left5", bus.out_data, 32'h0F);
        // reset asserted mid-stall clears state at once
        tick(); bus.in_pullThreshold = 0; bus.in_bitReqLength = 0;
        tick(); tick();
        #3 reset = 1;
        #1 chk("t8_rst_count", bus.out_shiftCount, 32); chk("t8_rst_empty", bus.out_empty, 1);
        tick(); bus.in_outEnable = 0; bus.in_autoPullEnable = 0; reset = 0;
        neg(); chk("t8_idle_stall", bus.out_stall, 0); chk("t8_idle_data", bus.out_data, 0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
